div_share_arbiter: RTL
======================

DIV_SHARE_ARBITER -- requirements
Module: div_share_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  NUM_LENGTH  8   numerator/quotient width, matching the divider
  DEN_LENGTH  8   denominator/remainder width, matching the divider
  TIMEOUT_CYCLES  64   WAIT-state watchdog limit; used only under DIV_ARB_TIMEOUT_EN
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock, rising edge
  rst  in  1  asynchronous, active-low reset
  req_valid  in  4  per-requester request strobe
  req_num  in  4*NUM_LENGTH  numerators; requester i at [i*NUM_LENGTH +: NUM_LENGTH]
  req_den  in  4*DEN_LENGTH  denominators; requester i at [i*DEN_LENGTH +: DEN_LENGTH]
  req_ready  out  4  one-hot grant; the request transfers in this cycle
  rsp_valid  out  4  one-hot, one-cycle result strobe to the owning requester
  rsp_quo  out  NUM_LENGTH  shared quotient bus
  rsp_rem  out  DEN_LENGTH  shared remainder bus
  rsp_err  out  1  timeout flag, qualified by rsp_valid
  div_num  out  NUM_LENGTH  operand to divider
  div_den  out  DEN_LENGTH  operand to divider
  div_nd_valid  out  1  operand strobe to divider
  div_nd_ready  in  1  divider idle/accepting
  div_qr_valid  in  1  divider one-cycle result strobe
  div_quo  in  NUM_LENGTH  divider quotient
  div_rem  in  DEN_LENGTH  divider remainder
REQ-003 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst; the divider SHALL share both clk and rst.

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT and RESP.
REQ-005 In IDLE with req_valid!=0 and div_nd_ready=1: grant one requester, pulse its req_ready bit for 1 cycle, latch its operands and index, go to ISSUE.
REQ-006 In IDLE with req_valid=0 or div_nd_ready=0: no grant, stay in IDLE.
REQ-007 Arbitration SHALL be round-robin: search starts at ptr and wraps 3->0; after a grant to i, ptr = (i+1) mod 4; ptr resets to 0.
REQ-008 Requesters SHALL hold req_valid and operands stable until their req_ready bit is seen; deasserting req_valid before the grant withdraws the request.
REQ-009 ISSUE SHALL last exactly 1 cycle: div_nd_valid=1 with the latched div_num/div_den, then go to WAIT; div_nd_valid SHALL be 0 in all other states.
REQ-010 In WAIT, when div_qr_valid=1: register div_quo/div_rem into rsp_quo/rsp_rem, set rsp_err=0, go to RESP.
REQ-011 In RESP: rsp_valid SHALL be one-hot at the latched index for exactly 1 cycle, then go to IDLE; rsp_quo/rsp_rem hold their values until the next response.
REQ-012 div_qr_valid seen outside WAIT SHALL be ignored.
REQ-013 Latency, grant cycle = 0: nonzero den gives rsp_valid in cycle NUM_LENGTH+4; den=0 gives rsp_valid in cycle 4 with quo=0, rem=0 (passed through from the divider).
REQ-014 The earliest next grant SHALL be the cycle after RESP; at most one operation SHALL be outstanding.
REQ-015 req_ready SHALL never assert in the same cycle as rsp_valid.
REQ-016 If rst asserts mid-operation, the in-flight request SHALL be dropped with no rsp_valid; requesters re-request.

Reset
REQ-017 On rst=0, asynchronously: state=IDLE, ptr=0, req_ready=0, rsp_valid=0, rsp_quo=0, rsp_rem=0, rsp_err=0, div_nd_valid=0, div_num=0, div_den=0, and the watchdog counter=0.

Configuration
REQ-018 Macro DIV_ARB_TIMEOUT_EN defined: a counter SHALL clear on entry to WAIT and increment each WAIT cycle; on reaching TIMEOUT_CYCLES without div_qr_valid, go to RESP with rsp_err=1, rsp_quo=0, rsp_rem=0; IDLE then waits for div_nd_ready before granting again.
REQ-019 Macro DIV_ARB_TIMEOUT_EN undefined: no counter SHALL be built, rsp_err SHALL be tied 0, and WAIT SHALL wait indefinitely.

Verification (NUM_LENGTH=DEN_LENGTH=8, real divider attached)
REQ-020 Single request: req 2 sends 100/7 -> req_ready[2] in cycle 0, rsp_valid=4'b0100 in cycle 12, quo=14, rem=2.
REQ-021 Divide by zero: req 0 sends 55/0 -> rsp_valid=4'b0001 in cycle 4, quo=0, rem=0, rsp_err=0.
REQ-022 Contention: all 4 requesters hold req_valid from reset -> grant order 0,1,2,3,0; each result returns to its owner; no two req_ready bits ever set together.
REQ-023 Fairness: req 0 and req 3 both hold requests continuously -> grants alternate 0,3,0,3.
REQ-024 Reset mid-operation: rst pulsed in cycle 5 of an operation -> all outputs 0, no rsp_valid, ptr=0, a fresh request completes normally.
REQ-025 Timeout (macro defined, TIMEOUT_CYCLES=4, divider model never asserts div_qr_valid) -> rsp_valid with rsp_err=1, quo=0, rem=0; no further grant while div_nd_ready=0.

Source files
------------

// File: rtl/div_share_arbiter.sv
// -----------------------------------------------------------------------------
// div_share_arbiter
//
// Shares one serial divider among four requesters. Requests are granted
// round-robin, one operation at a time. The operands are issued to the divider
// and its result is returned on a shared response bus. A one-hot rsp_valid
// strobe tells each requester which result belongs to it.
//
// Optional feature (compile-time macro DIV_ARB_TIMEOUT_EN):
//   When defined, a watchdog limits the time spent waiting for the divider to
//   TIMEOUT_CYCLES cycles. When it expires, the response reports rsp_err=1 with
//   a zero quotient and remainder. When undefined, rsp_err is tied low and the
//   block waits for the divider indefinitely.
//
// Parameters:
//   NUM_LENGTH      numerator/quotient width
//   DEN_LENGTH      denominator/remainder width
//   TIMEOUT_CYCLES  WAIT watchdog limit (DIV_ARB_TIMEOUT_EN only)
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   req_valid       per-requester request strobe
//   req_num/req_den packed operands, requester i at slice i
//   req_ready       one-hot grant pulse; the request transfers in this cycle
//   rsp_valid       one-hot, one-cycle result strobe
//   rsp_quo/rsp_rem shared result bus, held until the next response
//   rsp_err         watchdog timeout flag, qualified by rsp_valid
//   div_*           handshake and operands/results of the attached divider
// -----------------------------------------------------------------------------
module div_share_arbiter #(
    parameter int NUM_LENGTH     = 8,
    parameter int DEN_LENGTH     = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              req_valid,
    input  logic [4*NUM_LENGTH-1:0] req_num,
    input  logic [4*DEN_LENGTH-1:0] req_den,
    output logic [3:0]              req_ready,
    output logic [3:0]              rsp_valid,
    output logic [NUM_LENGTH-1:0]   rsp_quo,
    output logic [DEN_LENGTH-1:0]   rsp_rem,
    output logic                    rsp_err,
    output logic [NUM_LENGTH-1:0]   div_num,
    output logic [DEN_LENGTH-1:0]   div_den,
    output logic                    div_nd_valid,
    input  logic                    div_nd_ready,
    input  logic                    div_qr_valid,
    input  logic [NUM_LENGTH-1:0]   div_quo,
    input  logic [DEN_LENGTH-1:0]   div_rem
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    // A zero limit would make the watchdog meaningless.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t                  state_q;
    logic [1:0]              ptr_q;
    logic [1:0]              idx_q;
    logic [3:0]              req_ready_q;
    logic [3:0]              rsp_valid_q;
    logic [NUM_LENGTH-1:0]   rsp_quo_q;
    logic [DEN_LENGTH-1:0]   rsp_rem_q;
    logic [NUM_LENGTH-1:0]   div_num_q;
    logic [DEN_LENGTH-1:0]   div_den_q;
    logic                    div_nd_valid_q;

    logic [1:0]              pick;
    logic                    pick_ok;
    logic [1:0]              cand;

`ifdef DIV_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]         wd_q;
    logic                    rsp_err_q;
`endif

    // Round-robin search: the first active request at or after ptr_q, wrapping 3->0.
    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            cand = ptr_q + k[1:0];
            if (!pick_ok && req_valid[cand]) begin
                pick    = cand;
                pick_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            idx_q          <= '0;
            req_ready_q    <= '0;
            rsp_valid_q    <= '0;
            rsp_quo_q      <= '0;
            rsp_rem_q      <= '0;
            div_num_q      <= '0;
            div_den_q      <= '0;
            div_nd_valid_q <= 1'b0;
`ifdef DIV_ARB_TIMEOUT_EN
            wd_q           <= '0;
            rsp_err_q      <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle pulses unless a transition below sets them.
            req_ready_q    <= '0;
            rsp_valid_q    <= '0;
            div_nd_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pick_ok && div_nd_ready) begin
                        req_ready_q    <= 4'b0001 << pick;
                        idx_q          <= pick;
                        ptr_q          <= pick + 2'd1;
                        div_num_q      <= req_num[pick*NUM_LENGTH +: NUM_LENGTH];
                        div_den_q      <= req_den[pick*DEN_LENGTH +: DEN_LENGTH];
                        div_nd_valid_q <= 1'b1;
                        state_q        <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef DIV_ARB_TIMEOUT_EN
                    wd_q    <= '0;
`endif
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (div_qr_valid) begin
                        rsp_quo_q   <= div_quo;
                        rsp_rem_q   <= div_rem;
                        rsp_valid_q <= 4'b0001 << idx_q;
`ifdef DIV_ARB_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
`endif
                        state_q     <= RESP;
                    end
`ifdef DIV_ARB_TIMEOUT_EN
                    else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_quo_q   <= '0;
                        rsp_rem_q   <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 4'b0001 << idx_q;
                        state_q     <= RESP;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
`endif
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_quo      = rsp_quo_q;
    assign rsp_rem      = rsp_rem_q;
    assign div_num      = div_num_q;
    assign div_den      = div_den_q;
    assign div_nd_valid = div_nd_valid_q;
`ifdef DIV_ARB_TIMEOUT_EN
    assign rsp_err      = rsp_err_q;
`else
    assign rsp_err      = 1'b0;
`endif

endmodule
